// File: rtl/ysyx_22040895_csr_pkg.sv
// Shared encodings for the machine-mode CSR file and trap controller:
// op codes, CSR addresses, mstatus/mie bit positions, cause codes, FSM states.
package ysyx_22040895_csr_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'b000,
    OP_ECALL = 3'b001,
    OP_MRET  = 3'b010,
    OP_CSRRS = 3'b011,
    OP_CSRRW = 3'b100,
    OP_CSRRC = 3'b101
  } op_e;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;

  localparam int MS_MIE    = 3;
  localparam int MS_MPIE   = 7;
  localparam int MS_MPP_LO = 11;
  localparam int MS_MPP_HI = 12;

  localparam int IE_MTIE = 7;
  localparam int IE_MEIE = 11;

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_ECALL_M = 4'd11;
  localparam logic [3:0] CAUSE_MTI     = 4'd7;
  localparam logic [3:0] CAUSE_MEI     = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_TRAP     = 2'd1,
    S_REDIRECT = 2'd2
  } state_e;

  function automatic logic is_csr_op(input op_e op);
    return (op == OP_CSRRS) || (op == OP_CSRRW) || (op == OP_CSRRC);
  endfunction

endpackage

// File: rtl/ysyx_22040895_csr_regfile.sv
// CSR storage, read mux, write masking and the free-running mcycle counter.
// Trap/mret side effects on mstatus, mepc and mcause are applied here.
module ysyx_22040895_csr_regfile
  import ysyx_22040895_csr_pkg::*;
#(
  parameter int               XLEN        = 64,
  parameter logic [XLEN-1:0]  MTVEC_RESET = '0,
  parameter bit               VECTORED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     addr_i,
  output logic [XLEN-1:0] rdata_o,
  output logic            legal_o,
  input  logic            we_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            timer_irq_i,
  input  logic            ext_irq_i,
  input  logic            epc_we_i,
  input  logic [XLEN-1:0] epc_i,
  input  logic            cause_we_i,
  input  logic [XLEN-1:0] cause_i,
  input  logic            trap_i,
  input  logic            mret_i,
  output logic            mstatus_mie_o,
  output logic            mie_meie_o,
  output logic            mie_mtie_o,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o
);

  localparam logic [XLEN-1:0] MSTATUS_RST =
    {{(XLEN-13){1'b0}}, 13'h1800};
  localparam logic [XLEN-1:0] IE_MASK =
    {{(XLEN-12){1'b0}}, 12'h880};
  localparam logic [XLEN-1:0] EPC_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};
  localparam logic [XLEN-1:0] TVEC_MASK =
    VECTORED_EN ? '1 : EPC_MASK;

  logic [XLEN-1:0] mstatus_q, mie_q, mtvec_q, mscratch_q;
  logic [XLEN-1:0] mepc_q, mcause_q, mcycle_q, mip;

  always_comb begin
    mip = '0;
    mip[IE_MEIE] = ext_irq_i;
    mip[IE_MTIE] = timer_irq_i;
  end

  always_comb begin
    rdata_o = '0;
    legal_o = 1'b1;
    case (addr_i)
      CSR_MSTATUS:  rdata_o = mstatus_q;
      CSR_MIE:      rdata_o = mie_q;
      CSR_MTVEC:    rdata_o = mtvec_q & TVEC_MASK;
      CSR_MSCRATCH: rdata_o = mscratch_q;
      CSR_MEPC:     rdata_o = mepc_q;
      CSR_MCAUSE:   rdata_o = mcause_q;
      CSR_MIP:      rdata_o = mip;
      CSR_MCYCLE:   rdata_o = mcycle_q;
      default:      legal_o = 1'b0;
    endcase
  end

  function automatic logic wr(input logic [11:0] a);
    return we_i && (addr_i == a);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_q  <= MSTATUS_RST;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
    end else begin
      if (trap_i) begin
        mstatus_q[MS_MPIE] <= mstatus_q[MS_MIE];
        mstatus_q[MS_MIE]  <= 1'b0;
        mstatus_q[MS_MPP_HI:MS_MPP_LO] <= 2'b11;
      end else if (mret_i) begin
        mstatus_q[MS_MIE]  <= mstatus_q[MS_MPIE];
        mstatus_q[MS_MPIE] <= 1'b1;
        mstatus_q[MS_MPP_HI:MS_MPP_LO] <= 2'b11;
      end else if (wr(CSR_MSTATUS)) begin
        mstatus_q <= wdata_i;
      end
      if (wr(CSR_MIE))      mie_q      <= wdata_i & IE_MASK;
      if (wr(CSR_MTVEC))    mtvec_q    <= wdata_i;
      if (wr(CSR_MSCRATCH)) mscratch_q <= wdata_i;
      if (epc_we_i)         mepc_q     <= epc_i & EPC_MASK;
      else if (wr(CSR_MEPC)) mepc_q    <= wdata_i & EPC_MASK;
      if (cause_we_i)       mcause_q   <= cause_i;
      else if (wr(CSR_MCAUSE)) mcause_q <= wdata_i;
      // an explicit write takes precedence over the tick
      mcycle_q <= wr(CSR_MCYCLE) ? wdata_i : mcycle_q + 1'b1;
    end
  end

  assign mstatus_mie_o = mstatus_q[MS_MIE];
  assign mie_meie_o    = mie_q[IE_MEIE];
  assign mie_mtie_o    = mie_q[IE_MTIE];
  assign mtvec_o       = mtvec_q & TVEC_MASK;
  assign mepc_o        = mepc_q;

endmodule

// File: rtl/ysyx_22040895_csr_trap_unit.sv
// Machine-mode CSR/trap controller: accepts CSR ops, ecall and mret,
// takes timer/external interrupts and sequences the PC redirect to the IFU.
module ysyx_22040895_csr_trap_unit
  import ysyx_22040895_csr_pkg::*;
#(
  parameter int               XLEN        = 64,
  parameter logic [XLEN-1:0]  MTVEC_RESET = '0,
  parameter bit               VECTORED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            timer_irq_i,
  input  logic            ext_irq_i,
  output logic            out_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  input  logic            redirect_ready_i
);

  state_e          state_q, state_d;
  op_e             op;
  logic [XLEN-1:0] rdata, wdata, mtvec, mepc, cause, base, target;
  logic [XLEN-1:0] rpc_q, rpc_d, result_q;
  logic            legal, st_mie, ie_meie, ie_mtie;
  logic            accept, irq_ext, irq_tmr, irq_pend;
  logic            is_csr, csr_wr, illegal, take_trap;
  logic            do_csr, do_mret, we, in_trap;
  logic            irq_q, irq_d, out_valid_q;
  logic [3:0]      code_q, code_d;

  assign op       = op_e'(op_i);
  assign ready_o  = (state_q == S_IDLE);
  assign accept   = valid_i && ready_o;
  assign irq_ext  = st_mie && ie_meie && ext_irq_i;
  assign irq_tmr  = st_mie && ie_mtie && timer_irq_i;
  assign irq_pend = irq_ext || irq_tmr;

  assign is_csr    = is_csr_op(op);
  assign csr_wr    = (op == OP_CSRRW) || (|rs1_i);
  assign illegal   = is_csr &&
                     (!legal || (csr_addr_i == CSR_MIP && csr_wr));
  assign take_trap = accept &&
                     (irq_pend || illegal || op == OP_ECALL);
  assign do_csr    = accept && !irq_pend && is_csr && !illegal;
  assign do_mret   = accept && !irq_pend && (op == OP_MRET);
  assign we        = do_csr && csr_wr;
  assign in_trap   = (state_q == S_TRAP);

  always_comb begin
    wdata = rdata;
    case (op)
      OP_CSRRW: wdata = rs1_i;
      OP_CSRRS: wdata = rdata | rs1_i;
      OP_CSRRC: wdata = rdata & ~rs1_i;
      default:  wdata = rdata;
    endcase
  end

  assign cause  = {irq_q, {(XLEN-5){1'b0}}, code_q};
  assign base   = {mtvec[XLEN-1:2], 2'b00};
  assign target = (irq_q && mtvec[1:0] == 2'b01)
                ? base + {{(XLEN-6){1'b0}}, code_q, 2'b00}
                : base;

  always_comb begin
    state_d = state_q;
    rpc_d   = rpc_q;
    irq_d   = irq_q;
    code_d  = code_q;
    unique case (state_q)
      S_IDLE: begin
        if (take_trap) begin
          state_d = S_TRAP;
          irq_d   = irq_pend;
          if (irq_pend)
            code_d = irq_ext ? CAUSE_MEI : CAUSE_MTI;
          else
            code_d = illegal ? CAUSE_ILLEGAL : CAUSE_ECALL_M;
        end else if (do_mret) begin
          state_d = S_REDIRECT;
          rpc_d   = mepc;
        end
      end
      S_TRAP: begin
        state_d = S_REDIRECT;
        rpc_d   = target;
      end
      S_REDIRECT: begin
        if (redirect_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rpc_q       <= '0;
      irq_q       <= 1'b0;
      code_q      <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      rpc_q       <= rpc_d;
      irq_q       <= irq_d;
      code_q      <= code_d;
      out_valid_q <= do_csr;
      if (do_csr) result_q <= rdata;
    end
  end

  assign out_valid_o      = out_valid_q;
  assign result_o         = result_q;
  assign redirect_valid_o = (state_q == S_REDIRECT);
  assign redirect_pc_o    = rpc_q;

  ysyx_22040895_csr_regfile #(
    .XLEN        (XLEN),
    .MTVEC_RESET (MTVEC_RESET),
    .VECTORED_EN (VECTORED_EN)
  ) u_regfile (
    .clk           (clk),
    .rst           (rst),
    .addr_i        (csr_addr_i),
    .rdata_o       (rdata),
    .legal_o       (legal),
    .we_i          (we),
    .wdata_i       (wdata),
    .timer_irq_i   (timer_irq_i),
    .ext_irq_i     (ext_irq_i),
    .epc_we_i      (take_trap),
    .epc_i         (pc_i),
    .cause_we_i    (in_trap),
    .cause_i       (cause),
    .trap_i        (in_trap),
    .mret_i        (do_mret),
    .mstatus_mie_o (st_mie),
    .mie_meie_o    (ie_meie),
    .mie_mtie_o    (ie_mtie),
    .mtvec_o       (mtvec),
    .mepc_o        (mepc)
  );

endmodule

// File: tb/tb_ysyx_22040895_csr_trap_unit.sv
// Self-checking bench: directed scenarios plus randomized ops against a
// transaction-level model of the machine-mode CSRs and trap rules.
module tb_ysyx_22040895_csr_trap_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, ready_o;
  logic [2:0]  op_i;
  logic [11:0] csr_addr_i;
  logic [63:0] rs1_i, pc_i;
  logic        timer_irq_i, ext_irq_i;
  logic        out_valid_o;
  logic [63:0] result_o;
  logic        redirect_valid_o;
  logic [63:0] redirect_pc_o;
  logic        redirect_ready_i;

  always #5 clk = ~clk;

  ysyx_22040895_csr_trap_unit #(
    .XLEN        (64),
    .MTVEC_RESET (64'h0),
    .VECTORED_EN (1'b1)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .valid_i          (valid_i),
    .ready_o          (ready_o),
    .op_i             (op_i),
    .csr_addr_i       (csr_addr_i),
    .rs1_i            (rs1_i),
    .pc_i             (pc_i),
    .timer_irq_i      (timer_irq_i),
    .ext_irq_i        (ext_irq_i),
    .out_valid_o      (out_valid_o),
    .result_o         (result_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .redirect_ready_i (redirect_ready_i)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  localparam logic [2:0] ECALL = 3'd1, MRET = 3'd2;
  localparam logic [2:0] CSRRS = 3'd3, CSRRW = 3'd4, CSRRC = 3'd5;

  logic [63:0] m_status, m_mie, m_tvec, m_epc, m_cause, m_scratch;

  task automatic m_reset();
    m_status  = 64'h1800;
    m_mie     = 0;
    m_tvec    = 0;
    m_epc     = 0;
    m_cause   = 0;
    m_scratch = 0;
  endtask

  function automatic bit m_legal(input logic [11:0] a);
    return a inside {12'h300, 12'h304, 12'h305, 12'h340,
                     12'h341, 12'h342, 12'h344, 12'hB00};
  endfunction

  function automatic logic [63:0] m_read(input logic [11:0] a,
                                         input bit ext, input bit tmr);
    case (a)
      12'h300: return m_status;
      12'h304: return m_mie;
      12'h305: return m_tvec;
      12'h340: return m_scratch;
      12'h341: return m_epc;
      12'h342: return m_cause;
      12'h344: return (64'(ext) << 11) | (64'(tmr) << 7);
      default: return 0;
    endcase
  endfunction

  task automatic m_write(input logic [11:0] a, input logic [63:0] v);
    case (a)
      12'h300: m_status  = v;
      12'h304: m_mie     = v & 64'h880;
      12'h305: m_tvec    = v;
      12'h340: m_scratch = v;
      12'h341: m_epc     = v & ~64'h3;
      12'h342: m_cause   = v;
      default: ;
    endcase
  endtask

  task automatic do_op(input logic [2:0] op, input logic [11:0] a,
                       input logic [63:0] rs1, input logic [63:0] pc,
                       input bit ext, input bit tmr, input int hold,
                       output logic [63:0] res, output logic [63:0] rpc);
    bit pend, irq, trap, is_csr, wr, ill;
    logic [3:0] code;
    logic [63:0] old, nv, exp_pc;
    int n;
    pend   = m_status[3] && ((m_mie[11] && ext) || (m_mie[7] && tmr));
    is_csr = op inside {CSRRS, CSRRW, CSRRC};
    wr     = (op == CSRRW) || (rs1 != 0);
    ill    = is_csr && (!m_legal(a) || (a == 12'h344 && wr));
    trap = 0; irq = 0; code = 0; exp_pc = 0;
    if (pend) begin
      trap = 1; irq = 1;
      code = (m_mie[11] && ext) ? 4'd11 : 4'd7;
    end else if (ill) begin
      trap = 1; code = 4'd2;
    end else if (op == ECALL) begin
      trap = 1; code = 4'd11;
    end
    old = m_read(a, ext, tmr);
    check("ready_idle", 64'(ready_o), 1);
    valid_i = 1; op_i = op; csr_addr_i = a; rs1_i = rs1; pc_i = pc;
    ext_irq_i = ext; timer_irq_i = tmr;
    @(posedge clk); #1;
    valid_i = 0; op_i = 0;
    res = result_o; rpc = 0;
    if (!trap && is_csr) begin
      check("out_valid", 64'(out_valid_o), 1);
      if (a != 12'hB00) check("result", result_o, old);
      if (wr) begin
        nv = (op == CSRRW) ? rs1 : (op == CSRRS) ? (old | rs1) : (old & ~rs1);
        m_write(a, nv);
      end
    end else begin
      check("no_out_valid", 64'(out_valid_o), 0);
      if (trap) begin
        check("trap_cycle_quiet", 64'(redirect_valid_o), 0);
        m_epc   = pc & ~64'h3;
        m_cause = {irq, 59'b0, code};
        m_status[7] = m_status[3];
        m_status[3] = 1'b0;
        m_status[12:11] = 2'b11;
        exp_pc = m_tvec & ~64'h3;
        if (irq && m_tvec[1:0] == 2'b01) exp_pc = exp_pc + 4 * code;
      end else begin
        exp_pc = m_epc;
        m_status[3] = m_status[7];
        m_status[7] = 1'b1;
        m_status[12:11] = 2'b11;
      end
      ext_irq_i = 1'($urandom); timer_irq_i = 1'($urandom);
      n = 0;
      while (!redirect_valid_o && n < 4) begin
        @(posedge clk); #1; n++;
      end
      check("redirect_seen", 64'(redirect_valid_o), 1);
      check("redirect_pc", redirect_pc_o, exp_pc);
      rpc = redirect_pc_o;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("hold_valid", 64'(redirect_valid_o), 1);
        check("hold_pc", redirect_pc_o, exp_pc);
        check("hold_ready", 64'(ready_o), 0);
      end
      redirect_ready_i = 1;
      @(posedge clk); #1;
      redirect_ready_i = 0;
      check("redirect_done", 64'(redirect_valid_o), 0);
      check("ready_back", 64'(ready_o), 1);
      ext_irq_i = 0; timer_irq_i = 0;
    end
  endtask

  logic [63:0] res, rpc;
  logic [11:0] addrs [9] = '{12'h300, 12'h304, 12'h305, 12'h340,
                             12'h341, 12'h342, 12'h344, 12'h301, 12'h7C0};

  initial begin
    rst = 1; valid_i = 0; op_i = 0; csr_addr_i = 0; rs1_i = 0; pc_i = 0;
    timer_irq_i = 0; ext_irq_i = 0; redirect_ready_i = 0;
    m_reset();
    @(posedge clk); @(posedge clk); #1;
    check("rst_ready", 64'(ready_o), 1);
    check("rst_out_valid", 64'(out_valid_o), 0);
    check("rst_result", result_o, 0);
    check("rst_rdr_valid", 64'(redirect_valid_o), 0);
    check("rst_rdr_pc", redirect_pc_o, 0);
    rst = 0;
    @(posedge clk); #1;

    do_op(CSRRS, 12'h300, 0, 0, 0, 0, 0, res, rpc);
    check("rst_mstatus", res, 64'h1800);
    do_op(CSRRS, 12'h305, 0, 0, 0, 0, 0, res, rpc);
    check("rst_mtvec", res, 0);

    do_op(CSRRW, 12'h305, 64'h8000_0100, 0, 0, 0, 0, res, rpc);
    do_op(CSRRS, 12'h305, 0, 0, 0, 0, 0, res, rpc);
    check("mtvec_rw", res, 64'h8000_0100);
    do_op(CSRRS, 12'h305, 0, 0, 0, 0, 0, res, rpc);

    do_op(CSRRW, 12'h305, 64'h8000_0101, 0, 0, 0, 0, res, rpc);
    do_op(ECALL, 0, 0, 64'h8000_0040, 0, 0, 0, res, rpc);
    check("ecall_target", rpc, 64'h8000_0100);
    do_op(CSRRS, 12'h341, 0, 0, 0, 0, 0, res, rpc);
    check("ecall_mepc", res, 64'h8000_0040);
    do_op(CSRRS, 12'h342, 0, 0, 0, 0, 0, res, rpc);
    check("ecall_mcause", res, 64'd11);
    do_op(CSRRS, 12'h300, 0, 0, 0, 0, 0, res, rpc);
    check("ecall_mie_clr", 64'(res[3]), 0);

    do_op(CSRRS, 12'h300, 64'h8, 0, 0, 0, 0, res, rpc);
    do_op(CSRRW, 12'h304, 64'h80, 0, 0, 0, 0, res, rpc);
    do_op(CSRRW, 12'h340, 64'h123, 64'h8000_0080, 0, 1, 0, res, rpc);
    check("tmr_vec_target", rpc, 64'h8000_011C);
    do_op(CSRRS, 12'h342, 0, 0, 0, 0, 0, res, rpc);
    check("tmr_mcause", res, 64'h8000_0000_0000_0007);
    do_op(CSRRS, 12'h340, 0, 0, 0, 0, 0, res, rpc);
    check("tmr_op_suppressed", res, 0);

    do_op(CSRRS, 12'h300, 64'h8, 0, 0, 0, 0, res, rpc);
    do_op(CSRRW, 12'h304, 64'h880, 0, 0, 0, 0, res, rpc);
    do_op(CSRRS, 12'h340, 0, 64'h8000_0200, 1, 1, 0, res, rpc);
    check("both_irq_target", rpc, 64'h8000_012C);
    do_op(CSRRS, 12'h342, 0, 0, 0, 0, 0, res, rpc);
    check("ext_mcause", res, 64'h8000_0000_0000_000B);
    do_op(MRET, 0, 0, 0, 0, 0, 0, res, rpc);
    check("mret_target", rpc, 64'h8000_0200);
    do_op(CSRRS, 12'h300, 0, 0, 0, 0, 0, res, rpc);
    check("mret_mie", 64'(res[3]), 1);
    check("mret_mpie", 64'(res[7]), 1);

    do_op(ECALL, 0, 0, 64'h8000_0300, 0, 0, 5, res, rpc);

    do_op(CSRRW, 12'h300, 64'h1800, 0, 0, 0, 0, res, rpc);
    do_op(CSRRW, 12'h344, 64'h5, 64'h8000_0400, 0, 0, 0, res, rpc);
    do_op(CSRRS, 12'h342, 0, 0, 0, 0, 0, res, rpc);
    check("mip_wr_cause", res, 64'd2);
    do_op(CSRRS, 12'h344, 0, 0, 1, 1, 0, res, rpc);
    check("mip_read", res, 64'h880);

    do_op(CSRRW, 12'hB00, '1, 0, 0, 0, 0, res, rpc);
    do_op(CSRRS, 12'hB00, 0, 0, 0, 0, 0, res, rpc);
    check("mcycle_ones", res, '1);
    do_op(CSRRS, 12'hB00, 0, 0, 0, 0, 0, res, rpc);
    check("mcycle_wrap", res, 0);

    for (int it = 0; it < 300; it++) begin
      int r;
      logic [2:0] op;
      logic [63:0] rs1;
      r = $urandom_range(0, 9);
      op = (r == 0) ? ECALL : (r == 1) ? MRET : 3'(3 + $urandom_range(0, 2));
      rs1 = ($urandom_range(0, 1) == 0) ? 64'h0 : {$urandom, $urandom};
      do_op(op, addrs[$urandom_range(0, 8)], rs1, {$urandom, $urandom},
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            $urandom_range(0, 3), res, rpc);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    do_op(CSRRW, 12'h305, 64'h8000_0400, 0, 0, 0, 0, res, rpc);
    valid_i = 1; op_i = ECALL; pc_i = 64'h8000_0500;
    @(posedge clk); #1;
    valid_i = 0; op_i = 0;
    @(posedge clk); #1;
    check("pre_abort_valid", 64'(redirect_valid_o), 1);
    rst = 1;
    #1;
    check("abort_valid", 64'(redirect_valid_o), 0);
    check("abort_ready", 64'(ready_o), 1);
    check("abort_pc", redirect_pc_o, 0);
    @(posedge clk); #1;
    rst = 0;
    m_reset();
    @(posedge clk); #1;
    check("post_abort_valid", 64'(redirect_valid_o), 0);
    do_op(CSRRS, 12'h305, 0, 0, 0, 0, 0, res, rpc);
    check("abort_mtvec", res, 0);
    do_op(CSRRS, 12'h300, 0, 0, 0, 0, 0, res, rpc);
    do_op(CSRRS, 12'h341, 0, 0, 0, 0, 0, res, rpc);
    do_op(CSRRS, 12'h342, 0, 0, 0, 0, 0, res, rpc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
